store_data_lookup: RTL and testbench

STORE_DATA_LOOKUP -- requirements
Module: store_data_lookup

---
 rtl/store_data_lookup.sv | 127 ++++++++++++
 tb/tb_store_data_lookup.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_lookup.sv
// rtl/store_data_lookup.sv - store-data operand fetch: S0 (RF request / immediate), S1 (read in flight), OUT register
// Optional feature: define STORE_DATA_FWD_EN to let S0 capture a matching result-bus value instead of reading the RF.
module store_data_lookup #(
    parameter int TAG_W  = 7,
    parameter int SQN_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [SQN_W-1:0]  in_sqn,
    input  logic [1:0]        in_offs,
    output logic              rf_req,
    output logic [TAG_W-2:0]  rf_addr,
    input  logic              rf_gnt,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              br_taken,
    input  logic [SQN_W-1:0]  br_sqn,
    input  logic              br_flush,
    input  logic              fwd_valid,
    input  logic [TAG_W-1:0]  fwd_tag,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    output logic [SQN_W-1:0]  out_sqn,
    output logic [DATA_W-1:0] out_data
);

    // A stage dies when it is younger than the surviving store (wrapping compare) or on a full flush.
    function automatic logic f_kill(input logic [SQN_W-1:0] sqn, input logic taken,
                                    input logic flush, input logic [SQN_W-1:0] last_sqn);
        logic [SQN_W-1:0] diff;
        diff = sqn - last_sqn;
        return taken && (flush || ($signed(diff) > 0));
    endfunction

    logic              r_s0_v;
    logic [TAG_W-1:0]  r_s0_tag;
    logic [SQN_W-1:0]  r_s0_sqn;
    logic [1:0]        r_s0_offs;

    logic              r_s1_v;
    logic [SQN_W-1:0]  r_s1_sqn;
    logic [1:0]        r_s1_offs;
    logic              r_s1_from_rf;
    logic [DATA_W-1:0] r_s1_val;

    logic              r_out_v;
    logic [SQN_W-1:0]  r_out_sqn;
    logic [DATA_W-1:0] r_out_data;

    logic              w_s0_imm;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_s0_val;
    logic              w_kill_s0;
    logic              w_kill_s1;
    logic              w_kill_out;
    logic              w_s0_adv;
    logic              w_accept;
    logic [DATA_W-1:0] w_s1_val;
    logic [4:0]        w_shift;

    assign w_s0_imm = r_s0_tag[TAG_W-1];

`ifdef STORE_DATA_FWD_EN
    assign w_fwd_hit = fwd_valid && !w_s0_imm && (fwd_tag == r_s0_tag);
    assign w_s0_val  = w_s0_imm ? DATA_W'(r_s0_tag[TAG_W-2:0]) : fwd_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_valid, fwd_tag, fwd_data};
    assign w_fwd_hit    = 1'b0;
    assign w_s0_val     = DATA_W'(r_s0_tag[TAG_W-2:0]);
`endif

    assign w_kill_s0  = f_kill(r_s0_sqn,  br_taken, br_flush, br_sqn);
    assign w_kill_s1  = f_kill(r_s1_sqn,  br_taken, br_flush, br_sqn);
    assign w_kill_out = f_kill(r_out_sqn, br_taken, br_flush, br_sqn);

    // Forwarding wins over a grant, so a hit never consumes RF bandwidth.
    assign w_s0_adv = r_s0_v && !w_kill_s0 && (w_s0_imm || w_fwd_hit || rf_gnt);
    assign in_ready = !rst && !br_taken && (!r_s0_v || w_s0_adv);
    assign w_accept = in_valid && in_ready;

    assign rf_req  = !rst && r_s0_v && !w_s0_imm && !w_fwd_hit && !w_kill_s0;
    assign rf_addr = r_s0_tag[TAG_W-2:0];

    assign w_s1_val = r_s1_from_rf ? rf_data : r_s1_val;
    assign w_shift  = {r_s1_offs, 3'b000};

    assign out_valid = !rst && r_out_v && !w_kill_out;
    assign out_sqn   = r_out_sqn;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_v  <= 1'b0;
            r_s1_v  <= 1'b0;
            r_out_v <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s0_v <= 1'b1;
            end else if (w_s0_adv || w_kill_s0) begin
                r_s0_v <= 1'b0;
            end
            r_s1_v  <= w_s0_adv;
            r_out_v <= r_s1_v && !w_kill_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_tag  <= in_tag;
            r_s0_sqn  <= in_sqn;
            r_s0_offs <= in_offs;
        end
        if (w_s0_adv) begin
            r_s1_sqn     <= r_s0_sqn;
            r_s1_offs    <= r_s0_offs;
            r_s1_from_rf <= !w_s0_imm && !w_fwd_hit;
            r_s1_val     <= w_s0_val;
        end
        r_out_sqn  <= r_s1_sqn;
        r_out_data <= w_s1_val << w_shift;
    end

endmodule

// File: tb/tb_store_data_lookup.sv
// tb/tb_store_data_lookup.sv - directed scoreboard bench for store_data_lookup
module tb_store_data_lookup;
    localparam int TAG_W  = 7;
    localparam int SQN_W  = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TAG_W-1:0]  in_tag;
    logic [SQN_W-1:0]  in_sqn;
    logic [1:0]        in_offs;
    logic              rf_req;
    logic [TAG_W-2:0]  rf_addr;
    logic              rf_gnt;
    logic [DATA_W-1:0] rf_data;
    logic              br_taken;
    logic [SQN_W-1:0]  br_sqn;
    logic              br_flush;
    logic              fwd_valid;
    logic [TAG_W-1:0]  fwd_tag;
    logic [DATA_W-1:0] fwd_data;
    logic              out_valid;
    logic [SQN_W-1:0]  out_sqn;
    logic [DATA_W-1:0] out_data;

    always #5 clk = ~clk;

    store_data_lookup #(.TAG_W(TAG_W), .SQN_W(SQN_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_sqn(in_sqn), .in_offs(in_offs),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt), .rf_data(rf_data),
        .br_taken(br_taken), .br_sqn(br_sqn), .br_flush(br_flush),
        .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_sqn(out_sqn), .out_data(out_data)
    );

    typedef struct packed {
        logic [SQN_W-1:0]  sqn;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", {26'd0, out_sqn, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sqn_data", {26'd0, out_sqn, out_data}, {26'd0, e.sqn, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [TAG_W-1:0] tag, input logic [SQN_W-1:0] sqn, input logic [1:0] offs);
        in_valid = 1'b1;
        in_tag   = tag;
        in_sqn   = sqn;
        in_offs  = offs;
        @(negedge clk);
        chk("offer_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic watch(input int n, output int reqs, output int outs);
        reqs = 0;
        outs = 0;
        repeat (n) begin
            @(negedge clk);
            reqs += int'(rf_req);
            outs += int'(out_valid);
            tick();
        end
    endtask

    task automatic burst(input logic [SQN_W-1:0] s0, input logic [SQN_W-1:0] s1, input logic [SQN_W-1:0] s2,
                         input logic [SQN_W-1:0] bsqn, input logic flush, input logic [2:0] keep);
        int reqs, outs, total;
        if (keep[0]) exp_q.push_back('{sqn: s0, data: 32'd1});
        if (keep[1]) exp_q.push_back('{sqn: s1, data: 32'd2});
        if (keep[2]) exp_q.push_back('{sqn: s2, data: 32'd3});
        offer(7'h41, s0, 2'd0);
        offer(7'h42, s1, 2'd0);
        offer(7'h43, s2, 2'd0);
        in_valid = 1'b1;
        in_tag   = 7'h44;
        in_sqn   = 6'd30;
        br_taken = 1'b1;
        br_sqn   = bsqn;
        br_flush = flush;
        @(negedge clk);
        chk("br_in_ready", in_ready, 0);
        total = int'(out_valid);
        tick();
        in_valid = 1'b0;
        br_taken = 1'b0;
        br_flush = 1'b0;
        watch(4, reqs, outs);
        total += outs;
        chk("br_out_count", total, $countones(keep));
    endtask

    initial begin
        int reqs, outs, nreq;
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_sqn = '0; in_offs = '0;
        rf_gnt = 1'b0; rf_data = '0; br_taken = 1'b0; br_sqn = '0; br_flush = 1'b0;
        fwd_valid = 1'b0; fwd_tag = '0; fwd_data = '0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rf_req", rf_req, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        // basic register read with immediate grant: 3-cycle latency
        rf_gnt = 1'b1; rf_data = 32'hDEADBEEF;
        exp_q.push_back('{sqn: 6'd3, data: 32'hDEADBEEF});
        offer(7'h05, 6'd3, 2'd0);
        @(negedge clk);
        chk("t1_rf_req", rf_req, 1);
        chk("t1_rf_addr", rf_addr, 5);
        chk("t1_out_early1", out_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_out_early2", out_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_out_latency", out_valid, 1);
        tick();

        // grant withheld 4 cycles, offset 2
        rf_gnt = 1'b0; rf_data = 32'h000000AB;
        exp_q.push_back('{sqn: 6'd4, data: 32'h00AB0000});
        offer(7'h05, 6'd4, 2'd2);
        nreq = 0;
        repeat (4) begin
            @(negedge clk);
            nreq += int'(rf_req);
            chk("t2_hold_in_ready", in_ready, 0);
            tick();
        end
        rf_gnt = 1'b1;
        @(negedge clk);
        nreq += int'(rf_req);
        tick();
        chk("t2_req_cycles", nreq, 5);
        watch(4, reqs, outs);
        chk("t2_reqs_after", reqs, 0);
        chk("t2_outs", outs, 1);

        // immediate tag 0x41, offset 1
        rf_gnt = 1'b0;
        exp_q.push_back('{sqn: 6'd7, data: 32'h00000100});
        offer(7'h41, 6'd7, 2'd1);
        watch(4, reqs, outs);
        chk("t3_no_req", reqs, 0);
        chk("t3_outs", outs, 1);

        // branch kills across S0/S1/OUT
        burst(6'd4,  6'd5,  6'd6,  6'd4,  1'b0, 3'b001);
        burst(6'd4,  6'd5,  6'd6,  6'd5,  1'b0, 3'b011);
        burst(6'd62, 6'd63, 6'd0,  6'd62, 1'b0, 3'b001);
        burst(6'd10, 6'd11, 6'd12, 6'd20, 1'b1, 3'b000);

        // killed S0 must drop its request in the branch cycle
        rf_gnt = 1'b0;
        offer(7'h05, 6'd8, 2'd0);
        br_taken = 1'b1; br_sqn = 6'd7;
        @(negedge clk);
        chk("kill_s0_rf_req", rf_req, 0);
        tick();
        br_taken = 1'b0;
        watch(3, reqs, outs);
        chk("kill_s0_reqs", reqs, 0);
        chk("kill_s0_outs", outs, 0);

        // killed S1 discards returning RF data
        rf_gnt = 1'b1; rf_data = 32'h11112222;
        offer(7'h05, 6'd9, 2'd0);
        tick();
        br_taken = 1'b1; br_sqn = 6'd8;
        tick();
        br_taken = 1'b0;
        watch(3, reqs, outs);
        chk("kill_s1_outs", outs, 0);

        // forwarding from the result bus
        rf_gnt = 1'b1; rf_data = 32'hCAFEF00D;
        fwd_valid = 1'b1; fwd_tag = 7'h09; fwd_data = 32'h12345678;
`ifdef STORE_DATA_FWD_EN
        exp_q.push_back('{sqn: 6'd12, data: 32'h12345678});
`else
        exp_q.push_back('{sqn: 6'd12, data: 32'hCAFEF00D});
`endif
        offer(7'h09, 6'd12, 2'd0);
        watch(4, reqs, outs);
        fwd_valid = 1'b0;
`ifdef STORE_DATA_FWD_EN
        chk("fwd_reqs", reqs, 0);
`else
        chk("fwd_reqs", reqs, 1);
`endif
        chk("fwd_outs", outs, 1);

        // reset while S1 holds a read in flight
        rf_gnt = 1'b1; rf_data = 32'h55555555;
        offer(7'h05, 6'd13, 2'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_rf_req", rf_req, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", in_ready, 1);
        tick();
        watch(3, reqs, outs);
        chk("after_rst_outs", outs, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
